// File: rtl/settable_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// settable_mod_counter_pkg
//   Shared clock/calendar constants and small helpers for the settable modulo
//   counter family (seconds, minutes, hours, day-of-month).
//
//   Contents:
//     SEC_MAX, MIN_MAX, HOUR_MAX, DAY_MIN, DAY_MAX : standard counter limits
//     BCD_INVALID : digit code shown when a value cannot be shown in 2 digits
//     BCD_LIMIT   : largest value that fits in two BCD digits
//     action_e    : what the counter does in a given cycle
//     clamp16     : clamp a value into [lo, hi]
// -----------------------------------------------------------------------------
package settable_mod_counter_pkg;

   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MIN_MAX  = 59;
   localparam int unsigned HOUR_MAX = 23;
   localparam int unsigned DAY_MIN  = 1;
   localparam int unsigned DAY_MAX  = 31;

   localparam logic [3:0]  BCD_INVALID = 4'hF;
   localparam int unsigned BCD_LIMIT   = 99;

   typedef enum logic [1:0] {
      ACT_HOLD      = 2'd0,
      ACT_LOAD      = 2'd1,
      ACT_STEP_UP   = 2'd2,
      ACT_STEP_DOWN = 2'd3
   } action_e;

   // Counters are at most 16 bits wide, so a 16-bit clamp covers every width.
   function automatic logic [15:0] clamp16(input logic [15:0] v,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// -----------------------------------------------------------------------------
// bin2bcd_99
//   Purely combinational binary to two-digit BCD converter. Values above 99
//   cannot be shown in two digits, so both digits report BCD_INVALID.
//
//   Parameters:
//     WIDTH   input width in bits (4..16)
//   Ports:
//     i_bin   in  WIDTH  binary value
//     o_tens  out 4      tens digit, or BCD_INVALID
//     o_ones  out 4      ones digit, or BCD_INVALID
// -----------------------------------------------------------------------------
module bin2bcd_99
   import settable_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_bin,
   output logic [3:0]       o_tens,
   output logic [3:0]       o_ones
);

   // Widen to 16 bits so the range test and divide work for every WIDTH,
   // including widths too narrow to hold the constant 99.
   logic [15:0] bin_ext;
   logic        in_range;

   assign bin_ext  = 16'(i_bin);
   assign in_range = (bin_ext <= 16'(BCD_LIMIT));

   assign o_tens = in_range ? 4'(bin_ext / 16'd10) : BCD_INVALID;
   assign o_ones = in_range ? 4'(bin_ext % 16'd10) : BCD_INVALID;

endmodule

// File: rtl/settable_mod_counter.sv
// -----------------------------------------------------------------------------
// settable_mod_counter
//   Up/down modulo counter with runtime top value, wrap or saturate mode,
//   synchronous load and combinational carry/borrow pulses for chaining
//   (seconds -> minutes -> hours ...). Optional BCD digit outputs.
//
//   Parameters:
//     WIDTH   counter width in bits (4..16)
//     MIN     lowest count and wrap target
//     BCD_EN  1: drive BCD digits, 0: tie them to 0
//   Ports:
//     i_sysclk     in  1      clock, rising edge
//     i_reset_n    in  1      synchronous active-low reset (count -> MIN)
//     i_en         in  1      step enable
//     i_dir        in  1      1 = up, 0 = down
//     i_sat        in  1      0 = wrap, 1 = saturate
//     i_max        in  WIDTH  runtime top value (effective top = max(i_max, MIN))
//     i_load       in  1      load strobe, beats stepping
//     i_load_val   in  WIDTH  value to load (clamped to [MIN, top])
//     o_count      out WIDTH  current count
//     o_bcd_tens   out 4      BCD tens digit of o_count
//     o_bcd_ones   out 4      BCD ones digit of o_count
//     o_overflow   out 1      carry pulse, combinational
//     o_underflow  out 1      borrow pulse, combinational
// -----------------------------------------------------------------------------
module settable_mod_counter
   import settable_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MIN    = 0,
   parameter bit          BCD_EN = 1'b1
) (
   input  logic             i_sysclk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_sat,
   input  logic [WIDTH-1:0] i_max,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count,
   output logic [3:0]       o_bcd_tens,
   output logic [3:0]       o_bcd_ones,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] top;
   logic             at_top;
   logic             at_min;
   action_e          action;

   // A runtime i_max below MIN would make the range empty; MIN wins.
   assign top    = (i_max > MIN_W) ? i_max : MIN_W;
   assign at_top = (count_q >= top);
   assign at_min = (count_q <= MIN_W);

   // Reset is handled in the register itself, so it outranks everything here.
   always_comb begin
      if (i_load)    action = ACT_LOAD;
      else if (i_en) action = i_dir ? ACT_STEP_UP : ACT_STEP_DOWN;
      else           action = ACT_HOLD;
   end

   // NOTE: count_d takes a default before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      count_d = count_q;
      case (action)
         ACT_LOAD: begin
            count_d = WIDTH'(clamp16(16'(i_load_val), 16'(MIN_W), 16'(top)));
         end
         ACT_STEP_UP: begin
            // count >= top covers a count stranded above a lowered i_max:
            // it wraps (with carry) or saturates like a count sitting on top.
            if (!at_top)    count_d = count_q + ONE_W;
            else if (i_sat) count_d = top;
            else            count_d = MIN_W;
         end
         ACT_STEP_DOWN: begin
            // A count stranded above a lowered i_max drops straight to top.
            if (count_q > top) count_d = top;
            else if (!at_min)  count_d = count_q - ONE_W;
            else if (i_sat)    count_d = MIN_W;
            else               count_d = top;
         end
         default: count_d = count_q;
      endcase
   end

   // Pulses are zero-latency so a downstream counter enabled by them steps
   // on the very edge where this one wraps.
   assign o_overflow  = (action == ACT_STEP_UP)   & ~i_sat & at_top;
   assign o_underflow = (action == ACT_STEP_DOWN) & ~i_sat & at_min;

   // NOTE: sequential state is updated with non-blocking assignments so all
   // flops sample their inputs from the same pre-edge values.
   always_ff @(posedge i_sysclk) begin
      if (!i_reset_n) count_q <= MIN_W;
      else            count_q <= count_d;
   end

   assign o_count = count_q;

   generate
      if (BCD_EN) begin : g_bcd
         bin2bcd_99 #(
            .WIDTH (WIDTH)
         ) u_bin2bcd (
            .i_bin  (count_q),
            .o_tens (o_bcd_tens),
            .o_ones (o_bcd_ones)
         );
      end else begin : g_no_bcd
         assign o_bcd_tens = 4'd0;
         assign o_bcd_ones = 4'd0;
      end
   endgenerate

endmodule
